// File: rtl/core_ctrl_pkg.sv
// Shared control types for the multicycle RV32 core: PC selector codes,
// the major opcodes, the sequencer states and the instruction classes.
package core_ctrl_pkg;

  localparam logic [1:0] PC_4      = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    R,
    I,
    LOAD,
    STORE,
    BRANCH,
    ILL
  } opclass_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class decode, shared by the sequencer
// and the hazard/debug logic.
module opcode_classifier
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass
);

  always_comb begin
    opclass = ILL;
    case (opcode)
      OP_R:      opclass = R;
      OP_I:      opclass = I;
      OP_LOAD:   opclass = LOAD;
      OP_STORE:  opclass = STORE;
      OP_BRANCH: opclass = BRANCH;
      default:   opclass = ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV32 core.
// Define ILLEGAL_TRAP_EN to halt on unsupported opcodes instead of treating them as NOPs.
module multicycle_control_fsm
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             alu_src_imm,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             wb_sel_mem,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t   state, state_nxt;
  opclass_t cls_dec, cls_q;
  logic     retire;

  // The PC resolves the branch condition itself; zero is only routed through here.
  logic unused_zero;
  assign unused_zero = zero;

  opcode_classifier u_classifier (
    .opcode  (opcode),
    .opclass (cls_dec)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      cls_q       <= ILL;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) cls_q <= cls_dec;
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) illegal_q <= 1'b0;
    else if (state_nxt == HALT) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    wb_sel_mem  = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = PC_4;

    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write  = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        alu_src_imm = (cls_q == I) || (cls_q == LOAD) || (cls_q == STORE);
        case (cls_q)
          BRANCH: begin
            pc_write = 1'b1;
            pc_sel   = PC_BRANCH;
            retire   = 1'b1;
          end
          R, I:        state_nxt = WRITEBACK;
          LOAD, STORE: state_nxt = MEM;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nxt = HALT;
`else
            pc_write = 1'b1;
            retire   = 1'b1;
`endif
          end
        endcase
      end
      MEM: begin
        dmem_req    = 1'b1;
        alu_src_imm = 1'b1;
        dmem_we     = (cls_q == STORE);
        if (dmem_ready) begin
          if (cls_q == STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            state_nxt = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        wb_sel_mem = (cls_q == LOAD);
        pc_write   = 1'b1;
        retire     = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = IDLE;
    endcase

    // run is only looked at on an instruction boundary.
    if (retire) state_nxt = run ? FETCH : IDLE;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: random instruction stream with
// random memory latencies; per-instruction expectations checked at each retire.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;
  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_BAD = 7'h7F;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic run = 1'b0;
  logic [6:0] opcode = 7'h00;
  logic zero = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic imem_req, ir_write, alu_src_imm, dmem_req, dmem_we, wb_sel_mem;
  logic reg_write, pc_write, busy, illegal;
  logic [1:0] pc_sel;
  logic [CNT_W-1:0] instr_count;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .run         (run),
    .opcode      (opcode),
    .zero        (zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .ir_write    (ir_write),
    .alu_src_imm (alu_src_imm),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .wb_sel_mem  (wb_sel_mem),
    .reg_write   (reg_write),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .busy        (busy),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       rw;
    logic       wbm;
    int         imem_cyc;
    int         irw_cyc;
    int         dmem_cyc;
    int         we_cyc;
    int         rw_cyc;
    int         imm_cyc;
    int         busy_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_count = 0;
  int a_imem = 0, a_irw = 0, a_dmem = 0, a_we = 0, a_rw = 0, a_imm = 0, a_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] count_mod(input int n);
    return n % (1 << CNT_W);
  endfunction

  // Monitor: accumulate per-instruction activity, compare at each retire.
  always @(negedge clk) begin
    if (!arst_n) begin
      a_imem = 0; a_irw = 0; a_dmem = 0; a_we = 0; a_rw = 0; a_imm = 0; a_busy = 0;
    end else begin
      a_imem += int'(imem_req);
      a_irw  += int'(ir_write);
      a_dmem += int'(dmem_req);
      a_we   += int'(dmem_we);
      a_rw   += int'(reg_write);
      a_imm  += int'(alu_src_imm);
      a_busy += int'(busy);
      if (reg_write) chk("rw_with_we", {31'd0, dmem_we}, 32'd0);
      if (pc_write) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pc_sel", {30'd0, pc_sel}, {30'd0, e.sel});
          chk("reg_write_at_retire", {31'd0, reg_write}, {31'd0, e.rw});
          chk("wb_sel_mem", {31'd0, wb_sel_mem}, {31'd0, e.wbm});
          chk("imem_req_cycles", a_imem, e.imem_cyc);
          chk("ir_write_cycles", a_irw, e.irw_cyc);
          chk("dmem_req_cycles", a_dmem, e.dmem_cyc);
          chk("dmem_we_cycles", a_we, e.we_cyc);
          chk("reg_write_cycles", a_rw, e.rw_cyc);
          chk("alu_src_imm_cycles", a_imm, e.imm_cyc);
          chk("busy_cycles", a_busy, e.busy_cyc);
          chk("instr_count", {{(32-CNT_W){1'b0}}, instr_count}, count_mod(model_count));
          model_count++;
        end
        a_imem = 0; a_irw = 0; a_dmem = 0; a_we = 0; a_rw = 0; a_imm = 0; a_busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_imem_req(output bit ok);
    ok = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("imem_req_timeout", 32'd0, 32'd1);
  endtask

  // cls: 0=R 1=I 2=LOAD 3=STORE 4=BRANCH 5=illegal
  task automatic do_instr(input int cls, input bit drop_run);
    int n, m;
    bit ok, is_mem;
    logic [6:0] op;
    exp_t e;
    n = $urandom_range(0, 3);
    m = $urandom_range(0, 3);
    is_mem = (cls == 2) || (cls == 3);
    case (cls)
      0: op = OPC_R;
      1: op = OPC_I;
      2: op = OPC_LD;
      3: op = OPC_ST;
      4: op = OPC_BR;
      default: op = ($urandom_range(0, 1) == 0) ? OPC_BAD : 7'h37;
    endcase
    e.sel      = (cls == 4) ? 2'b01 : 2'b00;
    e.rw       = (cls <= 2);
    e.wbm      = (cls == 2);
    e.imem_cyc = n + 1;
    e.irw_cyc  = 1;
    e.dmem_cyc = is_mem ? m + 1 : 0;
    e.we_cyc   = (cls == 3) ? m + 1 : 0;
    e.rw_cyc   = (cls <= 2) ? 1 : 0;
    e.imm_cyc  = (cls == 1) ? 1 : (is_mem ? m + 2 : 0);
    e.busy_cyc = n + 3 + (is_mem ? m + 1 : 0) + ((cls <= 2) ? 1 : 0);

    wait_imem_req(ok);
    if (!ok) return;
    repeat (n) begin
      imem_ready = 1'b0;
      opcode = 7'($urandom);
      dmem_ready = 1'($urandom);
      zero = 1'($urandom);
      step();
    end
    imem_ready = 1'b1;
    opcode = op;
    dmem_ready = 1'($urandom);
    sb.push_back(e);
    step();
    // DECODE: run is ignored away from a boundary
    imem_ready = 1'b0;
    dmem_ready = 1'($urandom);
    zero = 1'($urandom);
    run = 1'($urandom);
    step();
    // EXECUTE
    run = 1'b1;
    dmem_ready = 1'($urandom);
    imem_ready = 1'($urandom);
    if (is_mem) begin
      step();
      if (drop_run) run = 1'b0;
      repeat (m) begin
        dmem_ready = 1'b0;
        imem_ready = 1'($urandom);
        step();
      end
      dmem_ready = 1'b1;
      imem_ready = 1'b0;
      step();
      dmem_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int max_cls;
`ifdef ILLEGAL_TRAP_EN
    max_cls = 4;
`else
    max_cls = 5;
`endif
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {{(32-CNT_W){1'b0}}, instr_count}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
    arst_n = 1'b1;
    step();
    chk("idle_no_run_busy", {31'd0, busy}, 32'd0);
    run = 1'b1;

    do_instr(0, 1'b0);
    do_instr(4, 1'b0);
    do_instr(2, 1'b0);
    do_instr(3, 1'b0);
    for (int k = 0; k < 36; k++) do_instr($urandom_range(0, max_cls), 1'b0);
    do_instr(2, 1'b1);

    // LOAD with run dropped retires, then the FSM rests in IDLE
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stopped_busy", {31'd0, busy}, 32'd0);
      chk("stopped_imem_req", {31'd0, imem_req}, 32'd0);
    end
    chk("final_count", {{(32-CNT_W){1'b0}}, instr_count}, count_mod(model_count));
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("retired_total", model_count, 32'd41);

    // Reset in the middle of a fetch
    run = 1'b1;
    wait_imem_req(ok);
    arst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_count", {{(32-CNT_W){1'b0}}, instr_count}, 32'd0);
    chk("midrst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("midrst_imem_req", {31'd0, imem_req}, 32'd0);
    step();
    arst_n = 1'b1;
    model_count = 0;

`ifdef ILLEGAL_TRAP_EN
    run = 1'b1;
    wait_imem_req(ok);
    imem_ready = 1'b1;
    opcode = OPC_BAD;
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halt_pc_write", {31'd0, pc_write}, 32'd0);
      chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
    end
    chk("halt_busy", {31'd0, busy}, 32'd1);
    chk("halt_illegal", {31'd0, illegal}, 32'd1);
    chk("halt_count", {{(32-CNT_W){1'b0}}, instr_count}, 32'd0);
    run = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("halt_rst_busy", {31'd0, busy}, 32'd0);
    chk("halt_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("halt_rst_count", {{(32-CNT_W){1'b0}}, instr_count}, 32'd0);
    step();
    arst_n = 1'b1;
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the Fibonacci RV32 core.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the enables for the IR, register file, ALU mux and data memory.
- Drives the program counter's pc_write/pc_sel so that the PC advances exactly once per instruction, in the instruction's final cycle.
- The PC is therefore stable at the current instruction's address throughout; branch target = pc + imm is computed from that address.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- arst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  input  7  instr[6:0] from IR; valid from DECODE onward
- zero  input  1  ALU rs1-rs2 zero flag; valid in EXECUTE
- imem_ready  input  1  instruction memory data valid
- dmem_ready  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- ir_write  output  1  latch instruction into IR
- alu_src_imm  output  1  ALU operand B = immediate
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write enable
- wb_sel_mem  output  1  writeback source = load data
- reg_write  output  1  register file write enable
- pc_write  output  1  PC update enable
- pc_sel  output  2  PC_4 or PC_BRANCH
- busy  output  1  FSM not in IDLE
- illegal  output  1  unsupported opcode flag
- instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low on arst_n.
- Reset state: state = IDLE, instr_count = 0, illegal = 0. All other outputs are Moore/Mealy-combinational and read 0 in IDLE (pc_sel = PC_4).
- Opcode classes, registered in DECODE:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011 (beq)
  - anything else = ILL
- IDLE: if run = 1, go to FETCH next cycle.
- FETCH:
  - imem_req = 1 continuously until imem_ready.
  - In the cycle imem_ready = 1: ir_write = 1, go to DECODE.
  - No timeout.
- DECODE: one cycle; register the opcode class; go to EXECUTE.
- EXECUTE (one cycle):
  - alu_src_imm = 1 for I, LOAD and STORE.
  - BRANCH: pc_write = 1, pc_sel = PC_BRANCH (the PC applies zero itself), retire.
  - R or I: go to WRITEBACK.
  - LOAD or STORE: go to MEM.
  - ILL: pc_write = 1, pc_sel = PC_4, retire (NOP behaviour).
- MEM:
  - dmem_req = 1 and alu_src_imm = 1 held; dmem_we = 1 for STORE only.
  - Wait for dmem_ready.
  - STORE: on dmem_ready, pc_write = 1, pc_sel = PC_4, retire.
  - LOAD: on dmem_ready, go to WRITEBACK.
- WRITEBACK: reg_write = 1, wb_sel_mem = (class == LOAD), pc_write = 1, pc_sel = PC_4, retire.
- Retire: instr_count += 1, wrapping at 2^CNT_W - 1 to 0. Next state is FETCH if run = 1, else IDLE.
- Invariants:
  - pc_write is high for exactly one cycle per instruction.
  - reg_write and dmem_we are never high in the same cycle.
- run low mid-instruction: the instruction completes normally. run is sampled only at retire and in IDLE.
- Memory ready behaviour: imem_ready/dmem_ready asserted outside their request state are ignored. Ready may arrive in the same cycle as the request (zero wait).
- Reset mid-operation: immediate return to IDLE; counter cleared; no partial writes.
- busy = (state != IDLE).

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - ILL in EXECUTE goes to HALT: no pc_write, no counter increment.
  - illegal = 1 sticky; busy = 1.
  - HALT is left only by reset.
- Undefined: ILL executes as NOP (see EXECUTE); illegal is tied to 0; no HALT state.

Decomposition:
- Package core_ctrl_pkg holds:
  - PC_4 = 2'b00, PC_BRANCH = 2'b01 (the existing PC's selector values)
  - opcode localparams
  - state_t enum {IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT}
  - opclass_t enum {R, I, LOAD, STORE, BRANCH, ILL}
- Sub-module opcode_classifier: combinational, opcode -> opclass_t; reusable by the hazard/debug logic.

Test Plan:
- Reset then run = 1, R-type, imem_ready after 2 wait cycles -> imem_req high for 3 cycles; DECODE, EXECUTE, WRITEBACK; reg_write = 1 and pc_write = 1 with pc_sel = 00 in the same cycle; instr_count = 1.
- beq with zero = 1 and imem_ready immediate -> pc_write = 1 with pc_sel = 01 in cycle 3 (EXECUTE); no reg_write; instr_count = 1.
- LOAD with dmem_ready after 3 cycles -> dmem_req held 4 cycles with dmem_we = 0; then WRITEBACK with wb_sel_mem = 1 and reg_write = 1.
- STORE -> dmem_we = 1 throughout MEM; pc_write in the dmem_ready cycle; reg_write never asserted.
- run dropped during MEM of a LOAD -> the LOAD retires; FSM enters IDLE; busy = 0; no further imem_req.
- opcode 7'h7F -> without macro: pc_write/PC_4 and count increments. With ILLEGAL_TRAP_EN: HALT, illegal = 1, no pc_write; arst_n low clears to IDLE with count = 0.
